// File: rtl/draw_pkg.sv
// Shared definitions for the draw scheduler: screen geometry, VGA field
// widths, scheduler state encoding and the on-screen test used for clipping.
package draw_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned X_BITS      = 8;
  localparam int unsigned Y_BITS      = 7;
  localparam int unsigned COLOUR_BITS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Sums arrive one bit wider than the VGA fields so off-screen carries are visible.
  function automatic logic on_screen(input logic [X_BITS:0] sx,
                                     input logic [Y_BITS:0] sy);
    return (sx < (X_BITS+1)'(SCREEN_W)) && (sy < (Y_BITS+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at last+1 (wrapping modulo N) and returns the first
// set bit as a one-hot grant plus its index. The pointer lives in the caller.
//   req   : request vector
//   last  : index of the previous winner
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted requester
//   valid : at least one request is present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!valid && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Shares one VGA plot port among NUM_REQ rectangle-fill requesters.
// A round-robin winner's rectangle is latched and streamed row-major, one
// pixel per clock, with off-screen pixels suppressed (plot=0) but still timed.
//   clk, resetn       : clock, asynchronous active-low reset
//   req               : per-requester request level
//   req_x/y/w/h/colour: packed per-requester rectangle (w,h are size minus 1)
//   ack               : one-cycle pulse when a request is latched
//   done              : one-cycle pulse when its rectangle has been streamed
//   busy              : high while drawing
//   x, y, colour, plot: registered pixel stream to the vga_adapter
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W_BITS  = 5,
  parameter int unsigned H_BITS  = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*X_BITS-1:0]      req_x,
  input  logic [NUM_REQ*Y_BITS-1:0]      req_y,
  input  logic [NUM_REQ*W_BITS-1:0]      req_w,
  input  logic [NUM_REQ*H_BITS-1:0]      req_h,
  input  logic [NUM_REQ*COLOUR_BITS-1:0] req_colour,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [X_BITS-1:0]              x,
  output logic [Y_BITS-1:0]              y,
  output logic [COLOUR_BITS-1:0]         colour,
  output logic                           plot
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t                 state;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       job_idx;
  logic [X_BITS-1:0]      x0;
  logic [Y_BITS-1:0]      y0;
  logic [W_BITS-1:0]      w_r, cx, ncx;
  logic [H_BITS-1:0]      h_r, cy, ncy;
  logic [COLOUR_BITS-1:0] col_r;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       g_idx;
  logic                   g_valid;

  int unsigned            gi;
  logic [X_BITS-1:0]      sel_x, bx;
  logic [Y_BITS-1:0]      sel_y, by;
  logic [W_BITS-1:0]      sel_w, ox;
  logic [H_BITS-1:0]      sel_h, oy;
  logic [COLOUR_BITS-1:0] sel_col;
  logic [X_BITS:0]        sx;
  logic [Y_BITS:0]        sy;
  logic                   last_px;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (g_idx),
    .valid (g_valid)
  );

  // The pixel for the next cycle: the grant's origin when starting a job,
  // otherwise the latched origin plus the advanced raster position.
  always_comb begin
    gi      = int'(g_idx);
    sel_x   = req_x[gi*X_BITS +: X_BITS];
    sel_y   = req_y[gi*Y_BITS +: Y_BITS];
    sel_w   = req_w[gi*W_BITS +: W_BITS];
    sel_h   = req_h[gi*H_BITS +: H_BITS];
    sel_col = req_colour[gi*COLOUR_BITS +: COLOUR_BITS];

    last_px = (cx == w_r) && (cy == h_r);
    if (cx == w_r) begin
      ncx = '0;
      ncy = cy + 1'b1;
    end else begin
      ncx = cx + 1'b1;
      ncy = cy;
    end

    if (state == IDLE) begin
      bx = sel_x;
      by = sel_y;
      ox = '0;
      oy = '0;
    end else begin
      bx = x0;
      by = y0;
      ox = ncx;
      oy = ncy;
    end
    sx = {1'b0, bx} + (X_BITS+1)'(ox);
    sy = {1'b0, by} + (Y_BITS+1)'(oy);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      last    <= IDX_W'(NUM_REQ - 1);
      job_idx <= '0;
      x0      <= '0;
      y0      <= '0;
      w_r     <= '0;
      h_r     <= '0;
      col_r   <= '0;
      cx      <= '0;
      cy      <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      ack     <= '0;
      done    <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          if (g_valid) begin
            x0      <= sel_x;
            y0      <= sel_y;
            w_r     <= sel_w;
            h_r     <= sel_h;
            col_r   <= sel_col;
            cx      <= '0;
            cy      <= '0;
            last    <= g_idx;
            job_idx <= g_idx;
            ack     <= grant;
            state   <= DRAW;
            x       <= sx[X_BITS-1:0];
            y       <= sy[Y_BITS-1:0];
            colour  <= sel_col;
            plot    <= on_screen(sx, sy);
            busy    <= 1'b1;
          end
        end
        DRAW: begin
          if (last_px) begin
            state <= IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= NUM_REQ'(1) << job_idx;
          end else begin
            cx     <= ncx;
            cy     <= ncy;
            x      <= sx[X_BITS-1:0];
            y      <= sy[Y_BITS-1:0];
            colour <= col_r;
            plot   <= on_screen(sx, sy);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [19:0] req_w;
  logic [11:0] req_h;
  logic [11:0] req_colour;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  int passed = 0;
  int total  = 0;

  draw_scheduler #(
    .NUM_REQ (4),
    .W_BITS  (5),
    .H_BITS  (3)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .ack        (ack),
    .done       (done),
    .busy       (busy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_job(input int i, input int xv, input int yv,
                         input int wv, input int hv, input int cv);
    req_x[8*i +: 8]      = xv[7:0];
    req_y[7*i +: 7]      = yv[6:0];
    req_w[5*i +: 5]      = wv[4:0];
    req_h[3*i +: 3]      = hv[2:0];
    req_colour[3*i +: 3] = cv[2:0];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({x, y, colour, plot, busy, ack, done} !== 28'd0)
      $display("FAIL reset_outputs x=%0d y=%0d c=%0d plot=%b busy=%b ack=%b done=%b required all zero",
               x, y, colour, plot, busy, ack, done);
    else passed++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({plot, busy, ack, done} !== 10'd0)
      $display("FAIL idle_no_req plot=%b busy=%b ack=%b done=%b required 0", plot, busy, ack, done);
    else passed++;
  endtask

  task automatic test_single_brick();
    int ex, ey;
    set_job(1, 16, 8, 15, 3, 2);
    req = 4'b0010;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (ack !== 4'b0010) $display("FAIL brick_ack got=%b required=0010", ack);
        else passed++;
        req = '0;
      end
      if (k == 2) begin
        total++;
        if (ack !== 4'b0000) $display("FAIL brick_ack_pulse got=%b required=0000", ack);
        else passed++;
      end
      if (k <= 64) begin
        ex = 16 + (k - 1) % 16;
        ey = 8 + (k - 1) / 16;
        total++;
        if (x !== ex[7:0] || y !== ey[6:0] || colour !== 3'b010 || plot !== 1'b1 ||
            busy !== 1'b1 || done !== 4'b0000)
          $display("FAIL brick_px k=%0d got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b required x=%0d y=%0d c=2 plot=1 busy=1",
                   k, x, y, colour, plot, busy, done, ex, ey);
        else passed++;
      end else begin
        total++;
        if (done !== 4'b0010 || busy !== 1'b0 || plot !== 1'b0)
          $display("FAIL brick_done got done=%b busy=%b plot=%b required done=0010 busy=0 plot=0",
                   done, busy, plot);
        else passed++;
      end
    end
    @(negedge clk);
    total++;
    if (done !== 4'b0000) $display("FAIL brick_done_pulse got=%b required=0000", done);
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_job(0, 10, 10, 1, 0, 1);
    set_job(2, 50, 20, 1, 0, 4);
    req = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          total++;
          if (ack !== 4'b0001) $display("FAIL simul_ack0 got=%b required=0001", ack);
          else passed++;
          req = 4'b0100;
        end
        3: begin
          total++;
          if (done !== 4'b0001 || ack !== 4'b0000)
            $display("FAIL simul_done0 got done=%b ack=%b required done=0001 ack=0000", done, ack);
          else passed++;
        end
        4: begin
          total++;
          if (ack !== 4'b0100 || x !== 8'd50 || y !== 7'd20 || colour !== 3'd4)
            $display("FAIL simul_ack2 got ack=%b x=%0d y=%0d c=%0d required ack=0100 x=50 y=20 c=4",
                     ack, x, y, colour);
          else passed++;
          req = '0;
        end
        6: begin
          total++;
          if (done !== 4'b0100) $display("FAIL simul_done2 got=%b required=0100", done);
          else passed++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [5];
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
    exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) set_job(i, 4 * i, i, 0, 0, i);
    req = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        total++;
        if (ack !== exp_ack[k/2])
          $display("FAIL rr_order slot=%0d got=%b required=%b", k / 2, ack, exp_ack[k/2]);
        else passed++;
      end
      if (k == 2) begin
        total++;
        if (done !== 4'b0001) $display("FAIL rr_done0 got=%b required=0001", done);
        else passed++;
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clipping();
    int plots;
    plots = 0;
    set_job(0, 152, 118, 15, 3, 6);
    req = 4'b0001;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k <= 64 && plot === 1'b1) plots++;
      if (k == 1) begin
        total++;
        if (x !== 8'd152 || y !== 7'd118 || plot !== 1'b1)
          $display("FAIL clip_first got x=%0d y=%0d plot=%b required x=152 y=118 plot=1", x, y, plot);
        else passed++;
      end
      if (k == 9) begin
        total++;
        if (x !== 8'd160 || plot !== 1'b0 || busy !== 1'b1)
          $display("FAIL clip_x160 got x=%0d plot=%b busy=%b required x=160 plot=0 busy=1", x, plot, busy);
        else passed++;
      end
      if (k == 33) begin
        total++;
        if (x !== 8'd152 || y !== 7'd120 || plot !== 1'b0)
          $display("FAIL clip_y120 got x=%0d y=%0d plot=%b required x=152 y=120 plot=0", x, y, plot);
        else passed++;
      end
      if (k == 64) begin
        total++;
        if (x !== 8'd167 || y !== 7'd121 || busy !== 1'b1)
          $display("FAIL clip_last got x=%0d y=%0d busy=%b required x=167 y=121 busy=1", x, y, busy);
        else passed++;
      end
      if (k == 65) begin
        total++;
        if (done !== 4'b0001) $display("FAIL clip_done got=%b required=0001", done);
        else passed++;
      end
    end
    total++;
    if (plots != 16) $display("FAIL clip_count got=%0d required=16", plots);
    else passed++;
  endtask

  task automatic test_single_pixel();
    set_job(3, 0, 0, 0, 0, 7);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    total++;
    if (ack !== 4'b1000 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd7 || plot !== 1'b1)
      $display("FAIL pixel_draw got ack=%b x=%0d y=%0d c=%0d plot=%b required ack=1000 x=0 y=0 c=7 plot=1",
               ack, x, y, colour, plot);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 4'b1000 || plot !== 1'b0 || busy !== 1'b0)
      $display("FAIL pixel_done got done=%b plot=%b busy=%b required done=1000 plot=0 busy=0",
               done, plot, busy);
    else passed++;
  endtask

  task automatic test_param_change();
    int ex, ey;
    set_job(2, 40, 20, 3, 1, 5);
    req = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k == 2) set_job(2, 100, 60, 7, 7, 1);
      if (k <= 8) begin
        ex = 40 + (k - 1) % 4;
        ey = 20 + (k - 1) / 4;
        total++;
        if (x !== ex[7:0] || y !== ey[6:0] || colour !== 3'd5 || plot !== 1'b1)
          $display("FAIL param_px k=%0d got x=%0d y=%0d c=%0d plot=%b required x=%0d y=%0d c=5 plot=1",
                   k, x, y, colour, plot, ex, ey);
        else passed++;
      end else begin
        total++;
        if (done !== 4'b0100) $display("FAIL param_done got=%b required=0100", done);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    set_job(1, 16, 8, 15, 3, 2);
    req = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
    end
    resetn = 1'b0;
    #1;
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 4'b0000)
      $display("FAIL midreset_async got plot=%b busy=%b done=%b required 0", plot, busy, done);
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done !== 4'b0000 || plot !== 1'b0 || busy !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL midreset_abandon got=%0d active cycles required=0", stray);
    else passed++;

    set_job(3, 5, 5, 0, 0, 3);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    total++;
    if (ack !== 4'b1000) $display("FAIL midreset_sole3 got=%b required=1000", ack);
    else passed++;
    repeat (2) @(negedge clk);

    set_job(0, 1, 1, 0, 0, 1);
    resetn = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    req = 4'b1000;
    total++;
    if (ack !== 4'b0001) $display("FAIL midreset_ptr got=%b required=0001", ack);
    else passed++;
    @(negedge clk);
    req = '0;
    total++;
    if (done !== 4'b0001) $display("FAIL midreset_ptr_done got=%b required=0001", done);
    else passed++;
  endtask

  initial begin
    resetn = 1'b0;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    test_reset();
    test_single_brick();
    test_simultaneous();
    test_round_robin();
    test_clipping();
    test_single_pixel();
    test_param_change();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
